instr_prefetch_queue: RTL and testbench

//  Fetch-side front end feeding the pipeline's InstrF/decode register. Issues in-order

---
 rtl/instr_prefetch_queue.sv | 204 ++++++++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue
//   Fetch-side front end for the InstrF/decode register. Issues in-order word
//   reads to instruction memory, buffers the returned words with their PCs in a
//   DEPTH-entry FIFO and presents the head to decode. Stale fetches are
//   discarded after an execute-stage redirect by counting off the responses
//   that were still in flight.
//
//   Optional feature macro: PREFETCH_BYPASS_EN
//     defined   : a live response arriving while the FIFO is empty drives
//                 instr_valid/InstrF/PCF combinationally in the same cycle and,
//                 if decode advances, is consumed without entering the FIFO.
//     undefined : decode outputs come only from the FIFO head (one-cycle
//                 response-to-decode latency).
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  // Pointer, occupancy and drop-counter widths.
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = AW + 2;

  // Credit limits, widened so sums of counters never overflow in comparison.
  localparam logic [DW:0]   DEPTH_W   = (DW+1)'(DEPTH);
  localparam logic [DW:0]   MAX_OUT_W = (DW+1)'(MAX_OUT);
  localparam logic [DW:0]   CREDIT_W  = (DW+1)'(2 * MAX_OUT);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [DW-1:0] DROP_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] DROP_ONE  = DW'(1'b1);
  localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
  localparam logic [31:0]   PC_STEP   = 32'd4;
  localparam logic [31:0]   ALIGN_MSK = 32'hFFFF_FFFC;

  // FIFO storage: instruction word and its fetch address.
  logic [31:0]   fifo_data_r [DEPTH];
  logic [31:0]   fifo_pc_r   [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;

  // Fetch-side state.
  logic [31:0]   fetch_pc_r;   // address of the next request to issue
  logic [31:0]   rsp_pc_r;     // address belonging to the next live response
  logic [CW-1:0] out_cnt_r;    // live requests accepted but not yet answered
  logic [DW-1:0] drop_cnt_r;   // stale responses still to be discarded

  // Datapath decode.
  logic [DW:0]   out_ext_s;
  logic [DW:0]   count_ext_s;
  logic [DW:0]   drop_ext_s;
  logic [31:0]   redir_pc_s;
  logic          fifo_empty_s;
  logic          drop_zero_s;
  logic          issue_ok_s;
  logic          issue_s;
  logic          rsp_live_s;
  logic          rsp_drop_s;
  logic          bypass_s;
  logic          bypass_take_s;
  logic          push_s;
  logic          pop_s;
  logic          head_valid_s;
  logic [31:0]   head_instr_s;
  logic [31:0]   head_pc_s;

  assign out_ext_s    = (DW+1)'(out_cnt_r);
  assign count_ext_s  = (DW+1)'(count_r);
  assign drop_ext_s   = (DW+1)'(drop_cnt_r);
  assign redir_pc_s   = redirect_pc & ALIGN_MSK;
  assign fifo_empty_s = (count_r == CNT_ZERO);
  assign drop_zero_s  = (drop_cnt_r == DROP_ZERO);

  // A request may only go out if its eventual response is guaranteed a FIFO
  // slot, and if a later redirect cannot push drop_cnt past its range.
  assign issue_ok_s = !reset && !redirect
                   && (out_ext_s < MAX_OUT_W)
                   && ((out_ext_s + count_ext_s) < DEPTH_W)
                   && ((out_ext_s + drop_ext_s) < CREDIT_W);

  assign mem_req_valid = issue_ok_s;
  assign mem_req_addr  = fetch_pc_r;
  assign issue_s       = issue_ok_s && mem_req_ready;

  // Responses are live only once every stale one has been counted off; a
  // redirect in the same cycle turns the arriving response stale as well.
  assign rsp_live_s = mem_rsp_valid && drop_zero_s && !redirect;
  assign rsp_drop_s = mem_rsp_valid && !drop_zero_s && !redirect;

`ifdef PREFETCH_BYPASS_EN
  assign bypass_s = rsp_live_s && fifo_empty_s;
`else
  assign bypass_s = 1'b0;
`endif

  // A bypassed word taken by decode never needs a FIFO slot.
  assign bypass_take_s = bypass_s && advance;
  assign push_s        = rsp_live_s && !bypass_take_s;
  assign pop_s         = advance && !fifo_empty_s && !redirect;

  // Select what decode sees: FIFO head first, then a bypassed response, else NOP.
  always_comb begin
    head_valid_s = 1'b0;
    head_instr_s = NOP_WORD;
    head_pc_s    = 32'h0000_0000;
    if (!fifo_empty_s) begin
      head_valid_s = 1'b1;
      head_instr_s = fifo_data_r[rd_ptr_r];
      head_pc_s    = fifo_pc_r[rd_ptr_r];
    end else if (bypass_s) begin
      head_valid_s = 1'b1;
      head_instr_s = mem_rsp_data;
      head_pc_s    = rsp_pc_r;
    end else begin
      head_valid_s = 1'b0;
      head_instr_s = NOP_WORD;
      head_pc_s    = 32'h0000_0000;
    end
  end

  assign instr_valid = head_valid_s;
  assign InstrF      = head_instr_s;
  assign PCF         = head_pc_s;

  // Fetch/response PC tracking and the outstanding and drop credit counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_r <= RESET_PC;
      rsp_pc_r   <= RESET_PC;
      out_cnt_r  <= CNT_ZERO;
      drop_cnt_r <= DROP_ZERO;
    end else if (redirect) begin
      // Everything still in flight becomes stale, minus a response that is
      // being discarded right now.
      fetch_pc_r <= redir_pc_s;
      rsp_pc_r   <= redir_pc_s;
      out_cnt_r  <= CNT_ZERO;
      drop_cnt_r <= drop_cnt_r + DW'(out_cnt_r) - DW'(mem_rsp_valid);
    end else begin
      if (issue_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end
      if (rsp_live_s) begin
        rsp_pc_r <= rsp_pc_r + PC_STEP;
      end
      out_cnt_r <= out_cnt_r + CW'(issue_s) - CW'(rsp_live_s);
      if (rsp_drop_s) begin
        drop_cnt_r <= drop_cnt_r - DROP_ONE;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue outright.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (redirect) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // FIFO entry storage; contents are cleared on reset so no stale word can leak.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_data_r[i] <= 32'h0000_0000;
        fifo_pc_r[i]   <= 32'h0000_0000;
      end
    end else if (push_s) begin
      fifo_data_r[wr_ptr_r] <= mem_rsp_data;
      fifo_pc_r[wr_ptr_r]   <= rsp_pc_r;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: self-checking bench for instr_prefetch_queue.
// A memory model answers every accepted request in order after a set latency;
// each accepted request pushes its expected {pc, word} to a scoreboard, which
// is popped and compared whenever decode consumes an instruction.
`timescale 1ns/1ps
module tb_instr_prefetch_queue;

  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'hE1A0_0000;
`ifdef PREFETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'h0;
  logic        instr_valid;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic        advance = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  always #5 clk = ~clk;

  instr_prefetch_queue dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .instr_valid(instr_valid), .InstrF(InstrF), .PCF(PCF),
    .advance(advance), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] due; } mreq_t;
  typedef struct {
    int lat; int rdy_mode; int adv_mode; int cycles; int max_pend;
    int gap_after; int exp_iv; int exp_rv; int exp_sb;
  } phase_t;

  exp_t        sb_q[$];
  mreq_t       mem_q[$];
  phase_t      ph[5];
  int          n_checks = 0;
  int          n_fail = 0;
  int          lat = 1;
  int          max_pend = 2 * MAX_OUT;
  int          pend = 0;
  bit          chk_gap = 1'b0;
  logic [31:0] cyc = 32'd0;
  logic [31:0] last_due = 32'd0;
  logic [31:0] exp_fetch = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample on the falling edge, then the memory drives its response.
  task automatic tick();
    exp_t  e;
    mreq_t m;
    @(negedge clk);
    pend = mem_q.size() + int'(mem_rsp_valid);
    check("outstanding_within_limit", 32'(pend <= max_pend), 32'd1);
    if (redirect) check("no_request_during_redirect", 32'(mem_req_valid), 32'd0);
    if (mem_req_valid && mem_req_ready) begin
      check("request_addr", mem_req_addr, exp_fetch);
      sb_q.push_back('{pc: mem_req_addr, data: mem_word(mem_req_addr)});
      m.addr = mem_req_addr;
      m.due  = (cyc + 32'(lat) > last_due) ? cyc + 32'(lat) : last_due + 32'd1;
      last_due = m.due;
      mem_q.push_back(m);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (redirect) begin
      sb_q.delete();
      exp_fetch = redirect_pc & 32'hFFFF_FFFC;
    end else if (instr_valid && advance) begin
      if (sb_q.size() > 0) e = sb_q.pop_front();
      else e = '{pc: 32'hFFFF_FFFF, data: 32'hFFFF_FFFF};
      check("consumed_pc", PCF, e.pc);
      check("consumed_word", InstrF, e.data);
    end
    if (chk_gap) check("no_gap_in_stream", 32'(instr_valid), 32'd1);
    @(posedge clk);
    #1;
    cyc = cyc + 32'd1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(m.addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
    end
  endtask

  // Wait (bounded) until decode sees an instruction, then check its PC and word.
  task automatic expect_first(input string name, input logic [31:0] pc);
    for (int i = 0; i < 40; i++) begin
      #1;
      if (instr_valid) break;
      tick();
    end
    #1;
    check({name, "_valid"}, 32'(instr_valid), 32'd1);
    check({name, "_pc"}, PCF, pc);
    check({name, "_word"}, InstrF, mem_word(pc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // lat, ready mode (0 on,1 toggle,2 random), advance mode, cycles, max outstanding,
    // gap-free after cycle, expected instr_valid / mem_req_valid / scoreboard depth
    ph[0] = '{1, 0, 0, 40, 2, 10,  1,  1, -1};
    ph[1] = '{1, 0, 1, 12, 2, -1,  1,  0,  4};
    ph[2] = '{3, 1, 0, 60, 2, -1, -1, -1, -1};
    ph[3] = '{2, 2, 2, 150, 2, -1, -1, -1, -1};
    ph[4] = '{1, 0, 0, 30, 2, 10,  1,  1, -1};

    // Reset state
    #3 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_instr_valid", 32'(instr_valid), 32'd0);
    check("reset_InstrF", InstrF, NOP_WORD);
    check("reset_PCF", PCF, 32'h0);
    check("reset_mem_req_valid", 32'(mem_req_valid), 32'd0);
    reset = 1'b0;

    // Response-to-decode latency, then fill with decode stalled
    mem_req_ready = 1'b1;
    advance = 1'b0;
    lat = 1;
    max_pend = MAX_OUT;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_rsp_valid) break;
    end
    #1;
    check("latency_rsp_seen", 32'(mem_rsp_valid), 32'd1);
    check("latency_same_cycle_valid", 32'(instr_valid), 32'(BYP));
    check("latency_same_cycle_word", InstrF, BYP ? mem_word(RESET_PC) : NOP_WORD);
    tick();
    #1;
    check("latency_next_cycle_valid", 32'(instr_valid), 32'd1);
    check("latency_next_cycle_pc", PCF, RESET_PC);
    repeat (10) tick();
    check("stall_buffered_words", 32'(sb_q.size()), 32'd4);
    check("stall_outstanding", 32'(mem_q.size() + int'(mem_rsp_valid)), 32'd0);
    check("stall_req_valid", 32'(mem_req_valid), 32'd0);
    check("stall_next_fetch", exp_fetch, 32'h10);

    // Table-driven phases
    for (int p = 0; p < 5; p++) begin
      lat = ph[p].lat;
      max_pend = ph[p].max_pend;
      for (int c = 0; c < ph[p].cycles; c++) begin
        case (ph[p].rdy_mode)
          0:       mem_req_ready = 1'b1;
          1:       mem_req_ready = 1'(c % 2);
          default: mem_req_ready = 1'($urandom_range(0, 1));
        endcase
        case (ph[p].adv_mode)
          0:       advance = 1'b1;
          1:       advance = 1'b0;
          default: advance = 1'($urandom_range(0, 1));
        endcase
        chk_gap = (ph[p].gap_after >= 0) && (c >= ph[p].gap_after);
        tick();
      end
      chk_gap = 1'b0;
      #1;
      if (ph[p].exp_iv >= 0) check("phase_end_instr_valid", 32'(instr_valid), 32'(ph[p].exp_iv));
      if (ph[p].exp_rv >= 0) check("phase_end_req_valid", 32'(mem_req_valid), 32'(ph[p].exp_rv));
      if (ph[p].exp_sb >= 0) check("phase_end_buffered", 32'(sb_q.size()), 32'(ph[p].exp_sb));
    end

    // Redirect with two requests in flight
    max_pend = 2 * MAX_OUT;
    lat = 3;
    mem_req_ready = 1'b1;
    advance = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_q.size() >= 2) break;
    end
    check("redirect_two_in_flight", 32'(mem_q.size() >= 2), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    expect_first("redirect_first", 32'h0000_0100);

    // Redirect with same-cycle response and advance, then a second redirect
    for (int i = 0; i < 30; i++) begin
      tick();
      if (mem_rsp_valid && mem_q.size() >= 1) break;
    end
    check("double_redirect_setup", 32'(mem_rsp_valid), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    advance = 1'b1;
    tick();
    #1;
    check("redirect_flushes_fifo", 32'(instr_valid), 32'd0);
    redirect_pc = 32'h0000_0300;
    tick();
    redirect = 1'b0;
    expect_first("double_redirect_first", 32'h0000_0300);

    // Asynchronous reset pulse between edges in mid-stream
    lat = 1;
    repeat (8) tick();
    #2 reset = 1'b1;
    #1;
    check("async_reset_instr_valid", 32'(instr_valid), 32'd0);
    check("async_reset_InstrF", InstrF, NOP_WORD);
    check("async_reset_PCF", PCF, 32'h0);
    check("async_reset_req_valid", 32'(mem_req_valid), 32'd0);
    mem_q.delete();
    sb_q.delete();
    mem_rsp_valid = 1'b0;
    mem_rsp_data = 32'h0;
    exp_fetch = RESET_PC;
    last_due = cyc;
    repeat (2) tick();
    reset = 1'b0;
    expect_first("restart_first", RESET_PC);
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
